video_timing_gen: RTL



---
 rtl/video_timing_gen.sv | 113 +++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel position counters, sync/blank decode and
// frame/line strobes for the HDMI pixel pipeline.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10
) (
  input  logic          pixel_clk,
  input  logic          reset,
  input  logic          pix_ce,
  input  logic [CW-1:0] irq_line,
  output logic [CW-1:0] drawX,
  output logic [CW-1:0] drawY,
  output logic          hs,
  output logic          vs,
  output logic          active_nblank,
  output logic          sync,
  output logic          line_start,
  output logic          frame_start,
  output logic          line_match,
  output logic [15:0]   frame_count
);

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [CW-1:0] next_x;
  logic [CW-1:0] next_y;
  logic          next_hs_on;
  logic          next_vs_on;
  logic          next_active;
  logic          next_line_start;
  logic          next_frame_start;
  logic          next_line_match;

  // Position one step ahead; every level output is decoded from it so all of
  // them describe the same pixel once registered.
  always_comb begin
    next_x = drawX;
    next_y = drawY;
    if (drawX == H_LAST) begin
      next_x = '0;
      next_y = (drawY == V_LAST) ? '0 : drawY + ONE;
    end else begin
      next_x = drawX + ONE;
    end
  end

  always_comb begin
    next_hs_on  = (int'(next_x) >= H_SYNC_START) && (int'(next_x) < H_SYNC_END);
    next_vs_on  = (int'(next_y) >= V_SYNC_START) && (int'(next_y) < V_SYNC_END);
    next_active = (int'(next_x) < H_ACTIVE) && (int'(next_y) < V_ACTIVE);
  end

  // irq_line values beyond the last line can never equal next_y.
  always_comb begin
    next_line_start  = (next_x == '0);
    next_frame_start = next_line_start && (next_y == '0);
    next_line_match  = next_line_start && (next_y == irq_line);
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      drawX         <= '0;
      drawY         <= '0;
      hs            <= ~HS_POL;
      vs            <= ~VS_POL;
      active_nblank <= 1'b1;
    end else if (pix_ce) begin
      drawX         <= next_x;
      drawY         <= next_y;
      hs            <= next_hs_on ? HS_POL : ~HS_POL;
      vs            <= next_vs_on ? VS_POL : ~VS_POL;
      active_nblank <= next_active;
    end
  end

  // Strobes only fire on a stepping cycle, so a held position never re-fires.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      line_match  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      line_start  <= pix_ce && next_line_start;
      frame_start <= pix_ce && next_frame_start;
      line_match  <= pix_ce && next_line_match;
      if (pix_ce && next_frame_start) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  assign sync = 1'b0;

endmodule
